aftab_dawu_multibeat: RTL and testbench
=======================================

# aftab_dawu_multibeat

Parametrised store unit for the AFTAB datapath. It accepts one store request (byte, half or word) and issues it to a memory port of configurable width (1, 2 or 4 byte lanes) as one or more aligned beats with per-lane byte enables, under a writeMem/memReady handshake. It is the successor of the byte-serial store unit: it keeps optional misalignment trapping and adds lane-parallel writes, so unaligned stores split across aligned memory words when trapping is off.

## Interface

Parameters:
- size, 32: address and store-data width.
- memBytes, 4: memory port width in bytes. Legal values are 1, 2 and 4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- addrIn  input  size  store byte address; sampled on start.
- dataIn  input  size  store data, right-aligned (byte 0 in bits 7:0); sampled on start.
- nBytes  input  2  store size: 2'b00 = 1 byte, 2'b01 = 2 bytes, 2'b11 = 4 bytes, 2'b10 = illegal.
- startDAWU  input  1  request strobe; honoured only in IDLE.
- memReady  input  1  memory accepts the current beat.
- checkMisalignedDAWU  input  1  when 1, trap misaligned or illegal requests instead of writing.
- addrOut  output  size  beat address, aligned to memBytes.
- dataOut  output  8*memBytes  beat data, bytes placed in their lanes.
- byteEn  output  memBytes  active lanes of the current beat.
- writeMem  output  1  beat valid.
- completeDAWU  output  1  one-cycle done pulse.
- storeMisalignedFlag  output  1  one-cycle trap pulse, coincident with completeDAWU.
- busy  output  1  high in any state other than IDLE.

## Operation

- State machine states: IDLE, WRITE, DONE.
- **IDLE, startDAWU=1:**
  - Register curAddr=addrIn, data=dataIn, rem=1/2/4 from nBytes.
  - A request is misaligned when it is a half with addr[0]=1, a word with addr[1:0]≠0, or nBytes=2'b10.
  - Misaligned and checkMisalignedDAWU=1: go to DONE with trap; no beat is issued.
  - Otherwise: go to WRITE.
  - With checkMisalignedDAWU=0, nBytes=2'b10 is treated as 4 bytes.
- **WRITE:** outputs are combinational from the registers.
  - off = curAddr mod memBytes.
  - k = min(rem, memBytes−off).
  - addrOut = curAddr with its low log2(memBytes) bits cleared.
  - byteEn bits off..off+k−1 set.
  - dataOut = low 8k bits of data shifted left by 8·off, with other lanes zero.
  - writeMem=1.
- **WRITE, on an edge with memReady=1:**
  - curAddr += k, rem −= k, data >>= 8k.
  - If rem becomes 0, go to DONE.
  - Otherwise stay in WRITE for the next beat.
- **DONE:**
  - completeDAWU=1 for this single cycle.
  - storeMisalignedFlag=1 if the request was trapped.
  - Return to IDLE on the next edge.
- startDAWU outside IDLE is ignored; there is no queueing.
- Address arithmetic is modulo 2^size; a carry past the top address wraps to 0.

## Timing

- **Reset (rst=0 at an edge):** state goes to IDLE and all registers clear. On the following cycle every output is 0: addrOut, dataOut, byteEn, writeMem, completeDAWU, storeMisalignedFlag, busy. Reset during WRITE aborts the store: writeMem is low from the cycle after that edge and no completeDAWU is issued.
- addrOut, dataOut and byteEn are zero whenever writeMem=0.
- Start accepted at edge t:
  - writeMem first high in cycle t+1.
  - Trap case: completeDAWU and storeMisalignedFlag high in cycle t+1, writeMem stays low.
- Beat handshake:
  - While writeMem=1 and memReady=0, addrOut, dataOut and byteEn hold stable.
  - A beat retires on each edge where writeMem=1 and memReady=1.
  - memReady already high in the first WRITE cycle gives a 1-cycle beat.
  - memReady is ignored when writeMem=0.
- **Minimum latency, start to completeDAWU:** 1 + beats + 1 cycles, where beats = ceil((off0+n)/memBytes). With memReady tied high: an aligned word at memBytes=4 completes in cycle t+2; the same word at memBytes=1 completes in cycle t+5.
- busy rises in cycle t+1 and falls after the DONE cycle.

## Test plan

- **memBytes=1, word store:** sw addr 0x100, data 0xAABBCCDD, memReady=1.
  - 4 beats: addrOut 0x100/0x101/0x102/0x103, dataOut 0xDD/0xCC/0xBB/0xAA, byteEn 1.
  - completeDAWU in cycle t+5.
- **memBytes=4, half store:** sh addr 0x102, data 0x00001234.
  - One beat: addrOut 0x100, byteEn 4'b1100, dataOut 0x12340000.
  - completeDAWU in cycle t+2.
- **memBytes=4, unaligned word, check=0:** sw addr 0x203, data 0x11223344.
  - Beat 1: 0x200, byteEn 4'b1000, dataOut 0x44000000.
  - Beat 2: 0x204, byteEn 4'b0111, dataOut 0x00112233.
- **Trap, check=1:** sw addr 0x101, then nBytes=2'b10 at addr 0x100.
  - Each request: storeMisalignedFlag=completeDAWU=1 for exactly one cycle (t+1); writeMem never rises.
- **Stall, memBytes=2:** sw addr 0x10, data 0xCAFEBABE, memReady low for 3 cycles per beat.
  - Outputs stable through each stall: beat 1 0x10/0xBABE, beat 2 0x12/0xCAFE, byteEn 2'b11.
  - Extra startDAWU pulses during the store are ignored.
- **Reset mid-operation:** rst=0 during beat 2 of the 0x203 case.
  - All outputs 0 on the next cycle and no completeDAWU.
  - A fresh sb to addr 0x7 then writes lane 3 of 0x4 correctly.

Source files
------------

// File: rtl/aftab_dawu_multibeat_if.sv
// -----------------------------------------------------------------------------
// aftab_dawu_multibeat_if
// Memory-side write port of the AFTAB multi-beat store unit.
//   addrOut   beat address, aligned to memBytes         (master -> slave)
//   dataOut   beat data, bytes placed in their lanes    (master -> slave)
//   byteEn    active byte lanes of the current beat     (master -> slave)
//   writeMem  beat valid                                (master -> slave)
//   memReady  memory accepts the current beat           (slave  -> master)
// -----------------------------------------------------------------------------
interface aftab_dawu_multibeat_if #(
   parameter int size     = 32,
   parameter int memBytes = 4
);
   logic [size-1:0]       addrOut;
   logic [8*memBytes-1:0] dataOut;
   logic [memBytes-1:0]   byteEn;
   logic                  writeMem;
   logic                  memReady;

   modport master (
      output addrOut, dataOut, byteEn, writeMem,
      input  memReady
   );

   modport slave (
      input  addrOut, dataOut, byteEn, writeMem,
      output memReady
   );
endinterface

// File: rtl/aftab_dawu_multibeat.sv
// -----------------------------------------------------------------------------
// aftab_dawu_multibeat
// Store unit for the AFTAB datapath. Takes one byte/half/word store request and
// issues it to a memory port of memBytes lanes (1, 2 or 4) as one or more
// aligned beats with per-lane byte enables. Unaligned stores are split across
// memory words unless misalignment trapping is enabled.
// Ports:
//   clk                  clock, rising edge
//   rst                  synchronous active-low reset
//   addrIn / dataIn      store address / right-aligned data, sampled on start
//   nBytes               00 = byte, 01 = half, 11 = word, 10 = illegal
//   startDAWU            request strobe, honoured only when idle
//   checkMisalignedDAWU  trap misaligned or illegal requests instead of writing
//   memBus               memory write port (addrOut/dataOut/byteEn/writeMem/memReady)
//   completeDAWU         one-cycle done pulse
//   storeMisalignedFlag  one-cycle trap pulse, coincident with completeDAWU
//   busy                 high whenever not idle
// -----------------------------------------------------------------------------
module aftab_dawu_multibeat #(
   parameter int size     = 32,
   parameter int memBytes = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [size-1:0]               addrIn,
   input  logic [size-1:0]               dataIn,
   input  logic [1:0]                    nBytes,
   input  logic                          startDAWU,
   input  logic                          checkMisalignedDAWU,
   aftab_dawu_multibeat_if.master        memBus,
   output logic                          completeDAWU,
   output logic                          storeMisalignedFlag,
   output logic                          busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [size-1:0] alignMask = size'(memBytes - 1);

   logic [1:0]      state;
   logic [size-1:0] curAddr;
   logic [size-1:0] data;
   logic [2:0]      rem;
   logic            trapped;

   logic [2:0]      off;
   logic [2:0]      space;
   logic [2:0]      k;
   logic [7:0]      enAll;
   logic [63:0]     kMask;
   logic [63:0]     laneData;
   logic            misaligned;
   logic [2:0]      reqBytes;

   // Current-beat geometry: lane offset inside the memory word and how many
   // bytes of the remaining store fit between that lane and the word's end.
   // NOTE: every signal written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      off      = 3'(curAddr % memBytes);
      space    = 3'(memBytes) - off;
      k        = (rem < space) ? rem : space;
      enAll    = ((8'd1 << k) - 8'd1) << off;
      kMask    = (64'd1 << {k, 3'b000}) - 64'd1;
      laneData = (64'(data) & kMask) << {off, 3'b000};
   end

   // Request decode. The illegal size 2'b10 writes as a word when not trapping.
   always_comb begin
      misaligned = 1'b0;
      reqBytes   = 3'd4;
      case (nBytes)
         2'b00: reqBytes = 3'd1;
         2'b01: begin
            reqBytes   = 3'd2;
            misaligned = addrIn[0];
         end
         2'b11: misaligned = (addrIn[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Bus outputs are forced to zero outside WRITE so the memory never sees
   // stale lanes while writeMem is low.
   always_comb begin
      memBus.addrOut  = '0;
      memBus.dataOut  = '0;
      memBus.byteEn   = '0;
      memBus.writeMem = 1'b0;
      if (state == WRITE) begin
         memBus.addrOut  = curAddr & ~alignMask;
         memBus.dataOut  = laneData[8*memBytes-1:0];
         memBus.byteEn   = enAll[memBytes-1:0];
         memBus.writeMem = 1'b1;
      end
   end

   assign completeDAWU        = (state == DONE);
   assign storeMisalignedFlag = (state == DONE) && trapped;
   assign busy                = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: the request registers are cleared on reset too; they feed the
         // bus outputs directly, and clearing them keeps a stale store from
         // resurfacing should the gating above ever change.
         state   <= IDLE;
         curAddr <= '0;
         data    <= '0;
         rem     <= '0;
         trapped <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (startDAWU) begin
                  curAddr <= addrIn;
                  data    <= dataIn;
                  rem     <= reqBytes;
                  if (misaligned && checkMisalignedDAWU) begin
                     trapped <= 1'b1;
                     state   <= DONE;
                  end else begin
                     trapped <= 1'b0;
                     state   <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (memReady_q()) begin
                  // Address wraps modulo 2^size by construction.
                  curAddr <= curAddr + size'(k);
                  rem     <= rem - k;
                  data    <= data >> {k, 3'b000};
                  if (rem == k) state <= DONE;
               end
            end
            DONE: begin
               trapped <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   function automatic logic memReady_q();
      return memBus.memReady;
   endfunction

endmodule

// File: tb/tb_aftab_dawu_multibeat.sv
// -----------------------------------------------------------------------------
// tb_aftab_dawu_multibeat
// Drives three store units (memBytes = 1, 2, 4) sharing request inputs, each
// with its own start strobe. Table of single-request vectors with the expected
// beat sequence, plus hand sequences for stalls, ignored starts and reset.
// -----------------------------------------------------------------------------
module tb_aftab_dawu_multibeat;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addrIn = '0;
   logic [31:0] dataIn = '0;
   logic [1:0]  nBytes = '0;
   logic        startReq = 1'b0;
   logic        checkMis = 1'b0;
   logic        memReady = 1'b0;
   int          sel = 4;

   logic start1, start2, start4;
   logic done1, done2, done4, flag1, flag2, flag4, busy1, busy2, busy4;

   assign start1 = startReq && (sel == 1);
   assign start2 = startReq && (sel == 2);
   assign start4 = startReq && (sel == 4);

   aftab_dawu_multibeat_if #(.size(32), .memBytes(1)) bus1 ();
   aftab_dawu_multibeat_if #(.size(32), .memBytes(2)) bus2 ();
   aftab_dawu_multibeat_if #(.size(32), .memBytes(4)) bus4 ();
   assign bus1.memReady = memReady;
   assign bus2.memReady = memReady;
   assign bus4.memReady = memReady;

   aftab_dawu_multibeat #(.size(32), .memBytes(1)) dut1 (
      .clk(clk), .rst(rst), .addrIn(addrIn), .dataIn(dataIn), .nBytes(nBytes),
      .startDAWU(start1), .checkMisalignedDAWU(checkMis), .memBus(bus1),
      .completeDAWU(done1), .storeMisalignedFlag(flag1), .busy(busy1));
   aftab_dawu_multibeat #(.size(32), .memBytes(2)) dut2 (
      .clk(clk), .rst(rst), .addrIn(addrIn), .dataIn(dataIn), .nBytes(nBytes),
      .startDAWU(start2), .checkMisalignedDAWU(checkMis), .memBus(bus2),
      .completeDAWU(done2), .storeMisalignedFlag(flag2), .busy(busy2));
   aftab_dawu_multibeat #(.size(32), .memBytes(4)) dut4 (
      .clk(clk), .rst(rst), .addrIn(addrIn), .dataIn(dataIn), .nBytes(nBytes),
      .startDAWU(start4), .checkMisalignedDAWU(checkMis), .memBus(bus4),
      .completeDAWU(done4), .storeMisalignedFlag(flag4), .busy(busy4));

   always #5 clk = ~clk;

   // Outputs of the selected unit, zero-extended to common widths.
   logic [31:0] oAddr, oData;
   logic [3:0]  oEn;
   logic        oWr, oDone, oFlag, oBusy;
   always_comb begin
      oAddr = '0; oData = '0; oEn = '0; oWr = 1'b0;
      oDone = 1'b0; oFlag = 1'b0; oBusy = 1'b0;
      case (sel)
         1: begin
            oAddr = bus1.addrOut; oData = 32'(bus1.dataOut); oEn = 4'(bus1.byteEn);
            oWr = bus1.writeMem; oDone = done1; oFlag = flag1; oBusy = busy1;
         end
         2: begin
            oAddr = bus2.addrOut; oData = 32'(bus2.dataOut); oEn = 4'(bus2.byteEn);
            oWr = bus2.writeMem; oDone = done2; oFlag = flag2; oBusy = busy2;
         end
         default: begin
            oAddr = bus4.addrOut; oData = 32'(bus4.dataOut); oEn = 4'(bus4.byteEn);
            oWr = bus4.writeMem; oDone = done4; oFlag = flag4; oBusy = busy4;
         end
      endcase
   end

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkIdle(input string tag);
      check({tag, " writeMem"}, 32'(oWr), 32'd0);
      check({tag, " addrOut"}, oAddr, 32'd0);
      check({tag, " dataOut"}, oData, 32'd0);
      check({tag, " byteEn"}, 32'(oEn), 32'd0);
   endtask

   task automatic checkBeat(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] e);
      check({tag, " writeMem"}, 32'(oWr), 32'd1);
      check({tag, " addrOut"}, oAddr, a);
      check({tag, " dataOut"}, oData, d);
      check({tag, " byteEn"}, 32'(oEn), 32'(e));
      check({tag, " busy"}, 32'(oBusy), 32'd1);
      check({tag, " completeDAWU"}, 32'(oDone), 32'd0);
   endtask

   // Issue a request at the next negedge; it is accepted on the following edge.
   task automatic issue(input int s, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] nb, input logic chk);
      @(negedge clk);
      sel = s; addrIn = a; dataIn = d; nBytes = nb; checkMis = chk;
      startReq = 1'b1;
   endtask

   typedef struct packed {
      logic [2:0]        sel;
      logic [31:0]       addr;
      logic [31:0]       data;
      logic [1:0]        nb;
      logic              chk;
      logic [2:0]        nBeats;
      logic              trap;
      logic [3:0][31:0]  eAddr;
      logic [3:0][31:0]  eData;
      logic [3:0][3:0]   eEn;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   initial begin
      // sel, addr, data, nBytes, chk, beats, trap, {addr3..0}, {data3..0}, {en3..0}
      vecs[0]  = '{3'd1, 32'h100, 32'hAABBCCDD, 2'b11, 1'b0, 3'd4, 1'b0,
                   {32'h103, 32'h102, 32'h101, 32'h100},
                   {32'hAA, 32'hBB, 32'hCC, 32'hDD}, {4'h1, 4'h1, 4'h1, 4'h1}};
      vecs[1]  = '{3'd4, 32'h102, 32'h00001234, 2'b01, 1'b0, 3'd1, 1'b0,
                   {32'h0, 32'h0, 32'h0, 32'h100},
                   {32'h0, 32'h0, 32'h0, 32'h12340000}, {4'h0, 4'h0, 4'h0, 4'b1100}};
      vecs[2]  = '{3'd4, 32'h203, 32'h11223344, 2'b11, 1'b0, 3'd2, 1'b0,
                   {32'h0, 32'h0, 32'h204, 32'h200},
                   {32'h0, 32'h0, 32'h00112233, 32'h44000000}, {4'h0, 4'h0, 4'b0111, 4'b1000}};
      vecs[3]  = '{3'd4, 32'h101, 32'h11223344, 2'b11, 1'b1, 3'd0, 1'b1,
                   '0, '0, '0};
      vecs[4]  = '{3'd4, 32'h100, 32'h11223344, 2'b10, 1'b1, 3'd0, 1'b1,
                   '0, '0, '0};
      vecs[5]  = '{3'd4, 32'h300, 32'hDEADBEEF, 2'b11, 1'b1, 3'd1, 1'b0,
                   {32'h0, 32'h0, 32'h0, 32'h300},
                   {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, {4'h0, 4'h0, 4'h0, 4'hF}};
      vecs[6]  = '{3'd4, 32'h100, 32'h55667788, 2'b10, 1'b0, 3'd1, 1'b0,
                   {32'h0, 32'h0, 32'h0, 32'h100},
                   {32'h0, 32'h0, 32'h0, 32'h55667788}, {4'h0, 4'h0, 4'h0, 4'hF}};
      vecs[7]  = '{3'd2, 32'h11, 32'h0000BEEF, 2'b01, 1'b0, 3'd2, 1'b0,
                   {32'h0, 32'h0, 32'h12, 32'h10},
                   {32'h0, 32'h0, 32'h00BE, 32'hEF00}, {4'h0, 4'h0, 4'b0001, 4'b0010}};
      vecs[8]  = '{3'd4, 32'hFFFFFFFE, 32'h44332211, 2'b11, 1'b0, 3'd2, 1'b0,
                   {32'h0, 32'h0, 32'h0, 32'hFFFFFFFC},
                   {32'h0, 32'h0, 32'h00004433, 32'h22110000}, {4'h0, 4'h0, 4'b0011, 4'b1100}};
      vecs[9]  = '{3'd1, 32'h5, 32'h00000077, 2'b00, 1'b0, 3'd1, 1'b0,
                   {32'h0, 32'h0, 32'h0, 32'h5},
                   {32'h0, 32'h0, 32'h0, 32'h77}, {4'h0, 4'h0, 4'h0, 4'h1}};
      vecs[10] = '{3'd2, 32'h11, 32'h0000BEEF, 2'b01, 1'b1, 3'd0, 1'b1,
                   '0, '0, '0};

      // ---- Reset state of all three units ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 1; s <= 4; s = s * 2) begin
         sel = s;
         #1;
         checkIdle($sformatf("reset mb%0d", s));
         check($sformatf("reset mb%0d done", s), 32'(oDone), 32'd0);
         check($sformatf("reset mb%0d flag", s), 32'(oFlag), 32'd0);
         check($sformatf("reset mb%0d busy", s), 32'(oBusy), 32'd0);
      end
      rst = 1'b1;
      memReady = 1'b1;

      // ---- Table-driven vectors, memReady tied high ----
      for (int v = 0; v < NV; v++) begin
         issue(int'(vecs[v].sel), vecs[v].addr, vecs[v].data, vecs[v].nb, vecs[v].chk);
         for (int b = 0; b < int'(vecs[v].nBeats); b++) begin
            @(negedge clk);
            startReq = 1'b0;
            checkBeat($sformatf("v%0d beat%0d", v, b), vecs[v].eAddr[b],
                      vecs[v].eData[b], vecs[v].eEn[b]);
         end
         @(negedge clk);
         startReq = 1'b0;
         check($sformatf("v%0d completeDAWU", v), 32'(oDone), 32'd1);
         check($sformatf("v%0d storeMisalignedFlag", v), 32'(oFlag), 32'(vecs[v].trap));
         check($sformatf("v%0d busy in DONE", v), 32'(oBusy), 32'd1);
         checkIdle($sformatf("v%0d DONE", v));
         @(negedge clk);
         check($sformatf("v%0d done pulse width", v), 32'(oDone), 32'd0);
         check($sformatf("v%0d flag pulse width", v), 32'(oFlag), 32'd0);
         check($sformatf("v%0d busy after", v), 32'(oBusy), 32'd0);
      end

      // ---- Stall on memBytes=2 with ignored start pulses ----
      memReady = 1'b0;
      issue(2, 32'h10, 32'hCAFEBABE, 2'b11, 1'b0);
      for (int b = 0; b < 2; b++) begin
         for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            startReq = (s == 1);
            addrIn = (s == 1) ? 32'h80 : 32'h10;
            dataIn = 32'h99999999;
            checkBeat($sformatf("stall b%0d c%0d", b, s), (b == 0) ? 32'h10 : 32'h12,
                      (b == 0) ? 32'hBABE : 32'hCAFE, 4'b0011);
            memReady = (s == 2);
         end
      end
      @(negedge clk);
      startReq = 1'b0;
      memReady = 1'b0;
      check("stall completeDAWU", 32'(oDone), 32'd1);
      check("stall flag", 32'(oFlag), 32'd0);
      @(negedge clk);
      check("stall done pulse width", 32'(oDone), 32'd0);
      check("stall busy after", 32'(oBusy), 32'd0);
      checkIdle("stall idle, memReady low");

      // ---- Reset during beat 2 of the 0x203 word on memBytes=4 ----
      memReady = 1'b1;
      issue(4, 32'h203, 32'h11223344, 2'b11, 1'b0);
      @(negedge clk);
      startReq = 1'b0;
      checkBeat("rst beat1", 32'h200, 32'h44000000, 4'b1000);
      @(negedge clk);
      memReady = 1'b0;
      checkBeat("rst beat2", 32'h204, 32'h00112233, 4'b0111);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checkIdle("after rst");
      check("after rst done", 32'(oDone), 32'd0);
      check("after rst flag", 32'(oFlag), 32'd0);
      check("after rst busy", 32'(oBusy), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("no complete after rst c%0d", c), 32'(oDone), 32'd0);
         check($sformatf("no write after rst c%0d", c), 32'(oWr), 32'd0);
      end

      // ---- Fresh sb to 0x7 after the aborted store ----
      memReady = 1'b1;
      issue(4, 32'h7, 32'h000000A5, 2'b00, 1'b0);
      @(negedge clk);
      startReq = 1'b0;
      checkBeat("sb 0x7", 32'h4, 32'hA5000000, 4'b1000);
      @(negedge clk);
      check("sb 0x7 completeDAWU", 32'(oDone), 32'd1);
      check("sb 0x7 flag", 32'(oFlag), 32'd0);
      @(negedge clk);
      check("sb 0x7 busy after", 32'(oBusy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Safety net in case the sequence above ever stops advancing.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (compared %0d)", compared);
      $fatal(1, "timeout");
   end

endmodule
